// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// Bundle for mem_port_arbiter: fetch port, data port, memory-unit drive and status.
// slave  = the arbiter's view (takes requests, drives acks and the memory unit).
// master = the environment's view (requesters plus the memory unit).
interface mem_port_arbiter_if;
  // fetch port: always a 32-bit read
  logic        f_req;
  logic [63:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  // data port: d_we=1 write, d_size 2=32-bit, 3=64-bit
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_ack;
  logic [63:0] d_rdata;
  // memory unit; mem_data_out is combinational read data
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [63:0] mem_data_in;
  logic [63:0] mem_data_out;
  // status
  logic        busy;
  logic        owner;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_data_out,
    output f_ack, f_rdata, d_ack, d_rdata,
    output mem_addr, mem_size, mem_read_en, mem_write_en, mem_data_in,
    output busy, owner
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_data_out,
    input  f_ack, f_rdata, d_ack, d_rdata,
    input  mem_addr, mem_size, mem_read_en, mem_write_en, mem_data_in,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Purpose: arbitrates a fetch port and a data port onto one single-ported memory unit.
// Latency: request sampled in IDLE at edge N -> LATENCY ACCESS cycles -> one-cycle ack (RESP).
// Backpressure: requesters hold req until ack; a losing requester simply waits for the next IDLE.
//
// Ports: clk, reset (synchronous, active-high); bus (mem_port_arbiter_if.slave) carrying
//   f_req/f_addr/f_ack/f_rdata, d_req/d_we/d_size/d_addr/d_wdata/d_ack/d_rdata,
//   mem_addr/mem_size/mem_read_en/mem_write_en/mem_data_in/mem_data_out, busy, owner.
// Parameter LATENCY: memory access cycles per transaction, 1..15.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the
//   data port wins every tie.
module mem_port_arbiter #(
  parameter int LATENCY = 1
) (
  input logic            clk,
  input logic            reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  count;
  logic        owner_q;
  logic        last_owner;
  logic        lat_we;
  logic [63:0] resp_q;

  // Registered outputs. The mem_* registers double as the latched request fields:
  // they are loaded at grant, held through ACCESS and cleared on leaving it.
  logic [63:0] mem_addr_q;
  logic [1:0]  mem_size_q;
  logic [63:0] mem_din_q;
  logic        rd_en_q;
  logic        wr_en_q;
  logic        f_ack_q;
  logic        d_ack_q;

  // Winner selection and the fields of the selected port (1 = data port).
  logic        grant_d;
  logic [63:0] sel_addr;
  logic [1:0]  sel_size;
  logic        sel_we;
  logic [63:0] sel_wdata;

  always_comb begin
    grant_d = bus.d_req;
    if (bus.f_req && bus.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_d = ~last_owner;
`else
      // Fixed priority: data always wins. last_owner is still tracked so both
      // builds carry identical state, but it cannot change the outcome here.
      grant_d = 1'b1 | last_owner;
`endif
    end

    if (grant_d) begin
      sel_addr  = bus.d_addr;
      sel_size  = bus.d_size;
      sel_we    = bus.d_we;
      sel_wdata = bus.d_wdata;
    end else begin
      sel_addr  = bus.f_addr;
      sel_size  = 2'd2;
      sel_we    = 1'b0;
      sel_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      owner_q    <= 1'b0;
      last_owner <= 1'b1;
      lat_we     <= 1'b0;
      resp_q     <= '0;
      mem_addr_q <= '0;
      mem_size_q <= '0;
      mem_din_q  <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      f_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.f_req || bus.d_req) begin
            owner_q    <= grant_d;
            last_owner <= grant_d;
            lat_we     <= sel_we;
            count      <= 4'(LATENCY - 1);
            mem_addr_q <= sel_addr;
            mem_size_q <= sel_size;
            mem_din_q  <= sel_wdata;
            rd_en_q    <= ~sel_we;
            // With a single access cycle the first ACCESS cycle is also the last.
            wr_en_q    <= sel_we && (LATENCY == 1);
            state      <= ACCESS;
          end
        end

        ACCESS: begin
          if (count == 4'd0) begin
            if (!lat_we) begin
              resp_q <= bus.mem_data_out;
            end
            mem_addr_q <= '0;
            mem_size_q <= '0;
            mem_din_q  <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            f_ack_q    <= ~owner_q;
            d_ack_q    <= owner_q;
            state      <= RESP;
          end else begin
            count   <= count - 4'd1;
            // Raise the write strobe for the cycle in which count reaches zero.
            wr_en_q <= lat_we && (count == 4'd1);
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.f_ack        = f_ack_q;
  assign bus.d_ack        = d_ack_q;
  assign bus.f_rdata      = resp_q[31:0];
  assign bus.d_rdata      = resp_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_size     = mem_size_q;
  assign bus.mem_data_in  = mem_din_q;
  assign bus.mem_read_en  = rd_en_q;
  assign bus.mem_write_en = wr_en_q;
  assign bus.busy         = (state != IDLE);
  assign bus.owner        = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: requesters and a memory unit around the DUT, a reference
// model predicting each transaction's winner/data/timing, and a monitor scoreboard.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Initial contents of memory: a fixed function of the address.
  function automatic logic [63:0] pattern(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  // ---------------- memory unit ----------------
  logic [63:0] store [logic [63:0]];

  always @(posedge clk)
    if (bus.mem_write_en && bus.mem_size >= 2'd2) store[bus.mem_addr] = bus.mem_data_in;

  always @(negedge clk) begin
    if (bus.mem_size >= 2'd2)
      bus.mem_data_out = store.exists(bus.mem_addr) ? store[bus.mem_addr] : pattern(bus.mem_addr);
    else
      bus.mem_data_out = 64'h0;
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          port;     // 0 fetch, 1 data
    bit          we;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;    // response register after this transaction
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ref_mem [logic [63:0]];
  bit          m_last_owner;
  logic [63:0] m_resp;

  // requester state, index 0 = fetch, 1 = data
  bit          pend [2];
  bit          p_we [2];
  logic [1:0]  p_size [2];
  logic [63:0] p_addr [2];
  logic [63:0] p_wdata [2];

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  task automatic drive_reqs();
    bus.f_req   = pend[0];
    bus.f_addr  = p_addr[0];
    bus.d_req   = pend[1];
    bus.d_we    = p_we[1];
    bus.d_size  = p_size[1];
    bus.d_addr  = p_addr[1];
    bus.d_wdata = p_wdata[1];
  endtask

  task automatic new_req(input int p);
    pend[p]   = 1'b1;
    p_addr[p] = 64'h1000 + 64'($urandom_range(0, 7)) * 64'd8;
    if (p == 0) begin
      p_we[0] = 1'b0; p_size[0] = 2'd2; p_wdata[0] = 64'h0;
    end else begin
      p_we[1]    = 1'($urandom_range(0, 1));
      p_size[1]  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      p_wdata[1] = {$urandom, $urandom};
    end
  endtask

  // Predict the transaction the DUT will grant at cycle sample_edge.
  task automatic predict(input int sample_edge, output bit w);
    exp_t e;
    if (pend[0] && pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      w = (m_last_owner == 1'b1) ? 1'b0 : 1'b1;
`else
      w = 1'b1;
`endif
    end else begin
      w = pend[1];
    end
    m_last_owner = w;
    e.port    = w;
    e.we      = p_we[w];
    e.size    = p_size[w];
    e.addr    = p_addr[w];
    e.wdata   = p_wdata[w];
    e.ack_cyc = sample_edge + LAT;
    if (e.we) begin
      if (e.size >= 2'd2) ref_mem[e.addr] = e.wdata;
    end else begin
      m_resp = (e.size >= 2'd2) ? ref_word(e.addr) : 64'h0;
    end
    e.rdata = m_resp;
    sb.push_back(e);
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.f_ack || bus.d_ack) got = 1'b1;
    end
    chk("ack_seen", 64'(got), 64'd1);
  endtask

  // Present current requests, predict, wait for the ack, drop the winner's req.
  task automatic serve(input int off);
    bit w, got;
    drive_reqs();
    predict(cyc + off, w);
    wait_ack(got);
    pend[w] = 1'b0;
    drive_reqs();
  endtask

  // ---------------- monitor ----------------
  int   acc_rd = 0;
  int   acc_wr = 0;
  int   n_ack  = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!bus.busy)
      chk("idle_quiet", 64'({bus.mem_read_en, bus.mem_write_en, bus.f_ack, bus.d_ack,
                             |bus.mem_addr, |bus.mem_size, |bus.mem_data_in}), 64'd0);
    if (bus.mem_read_en || bus.mem_write_en) begin
      chk("mem_access_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        chk("mem_addr", bus.mem_addr, sb[0].addr);
        chk("mem_size", 64'(bus.mem_size), 64'(sb[0].size));
        if (bus.mem_write_en) begin
          chk("mem_data_in", bus.mem_data_in, sb[0].wdata);
          chk("wr_final_cycle", 64'(cyc), 64'(sb[0].ack_cyc - 1));
        end
      end
    end
    if (bus.mem_read_en)  acc_rd++;
    if (bus.mem_write_en) acc_wr++;
    if (bus.f_ack || bus.d_ack) begin
      n_ack++;
      chk("single_ack", 64'(bus.f_ack & bus.d_ack), 64'd0);
      chk("resp_mem_quiet", 64'({bus.mem_read_en, bus.mem_write_en, |bus.mem_addr,
                                 |bus.mem_size, |bus.mem_data_in}), 64'd0);
      chk("ack_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("ack_port", 64'(bus.d_ack), 64'(mon_e.port));
        chk("ack_cycle", 64'(cyc), 64'(mon_e.ack_cyc));
        chk("owner", 64'(bus.owner), 64'(mon_e.port));
        chk("busy_in_resp", 64'(bus.busy), 64'd1);
        chk("rd_en_cycles", 64'(acc_rd), mon_e.we ? 64'd0 : 64'(LAT));
        chk("wr_en_cycles", 64'(acc_wr), mon_e.we ? 64'd1 : 64'd0);
        if (mon_e.port) chk("d_rdata", bus.d_rdata, mon_e.rdata);
        else            chk("f_rdata", 64'(bus.f_rdata), 64'(mon_e.rdata[31:0]));
      end
      acc_rd = 0;
      acc_wr = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    bit w;
    int off;
    int n_ack_before;

    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0; p_size[p] = 2'd2; p_addr[p] = '0; p_wdata[p] = '0;
    end
    drive_reqs();
    m_last_owner = 1'b1;
    m_resp       = 64'h0;
    store[64'h2000]   = 64'h0000_0000_8C40_0000;
    ref_mem[64'h2000] = 64'h0000_0000_8C40_0000;

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(bus.busy), 64'd0);
    chk("rst_owner",  64'(bus.owner), 64'd0);
    chk("rst_acks",   64'({bus.f_ack, bus.d_ack}), 64'd0);
    chk("rst_rdata",  bus.d_rdata | 64'(bus.f_rdata), 64'd0);
    chk("rst_mem_en", 64'({bus.mem_read_en, bus.mem_write_en}), 64'd0);
    chk("rst_mem_bus", bus.mem_addr | bus.mem_data_in | 64'(bus.mem_size), 64'd0);
    reset = 1'b0;

    // simultaneous requests, winner re-requests each time; then drain
    new_req(0);
    new_req(1);
    off = 1;
    for (int r = 0; r < 4; r++) begin
      serve(off);
      off = 2;
      for (int p = 0; p < 2; p++) if (!pend[p]) new_req(p);
    end
    while (pend[0] || pend[1]) serve(2);

    // fetch of 0x2000 returning 0x8C400000
    pend[0] = 1'b1; p_addr[0] = 64'h2000;
    serve(2);

    // 64-bit write then read-back through both ports
    pend[1] = 1'b1; p_we[1] = 1'b1; p_size[1] = 2'd3; p_addr[1] = 64'h100;
    p_wdata[1] = 64'hDEAD_BEEF_CAFE_F00D;
    serve(2);
    p_we[1] = 1'b0; pend[1] = 1'b1;
    serve(2);
    pend[0] = 1'b1; p_addr[0] = 64'h100;
    serve(2);

    // size 0 read forwarded unmodified; memory returns 0
    pend[1] = 1'b1; p_we[1] = 1'b0; p_size[1] = 2'd0; p_addr[1] = 64'h2000;
    serve(2);

    // data read of 0x200 with d_req dropped one cycle after grant
    @(negedge clk);
    pend[1] = 1'b1; p_we[1] = 1'b0; p_size[1] = 2'd3; p_addr[1] = 64'h200;
    drive_reqs();
    predict(cyc + 1, w);
    @(negedge clk);
    pend[1] = 1'b0;
    drive_reqs();
    wait_ack(got);
    repeat (3) begin
      @(negedge clk);
      chk("no_second_txn", 64'(bus.busy), 64'd0);
    end

    // reset during the 2nd ACCESS cycle of a write
    n_ack_before = n_ack;
    pend[1] = 1'b1; p_we[1] = 1'b1; p_size[1] = 2'd3; p_addr[1] = 64'h300;
    p_wdata[1] = 64'h1234_5678_9ABC_DEF0;
    drive_reqs();
    @(negedge clk);
    @(negedge clk);
    chk("owner_before_reset", 64'(bus.owner), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy",  64'(bus.busy), 64'd0);
    chk("rst_mid_owner", 64'(bus.owner), 64'd0);
    chk("rst_mid_rdata", bus.d_rdata, 64'd0);
    reset = 1'b0;
    pend[1] = 1'b0;
    drive_reqs();
    m_last_owner = 1'b1;
    m_resp       = 64'h0;
    repeat (6) @(negedge clk);
    chk("rst_no_ack",    64'(n_ack - n_ack_before), 64'd0);
    chk("rst_no_write",  64'(acc_wr), 64'd0);
    chk("rst_no_commit", 64'(store.exists(64'h300)), 64'd0);

    // randomized traffic
    off = 1;
    for (int r = 0; r < 60; r++) begin
      if (!pend[0] && !pend[1] && $urandom_range(0, 2) == 0) begin
        drive_reqs();
        repeat ($urandom_range(1, 3)) @(negedge clk);
        off = 1;
      end
      for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 3) != 0) new_req(p);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      serve(off);
      off = 2;
    end
    while (pend[0] || pend[1]) serve(2);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
